// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_pkg
// Description : Shared types and constants for the store buffer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

    localparam int STORE_DEPTH = 2;

    typedef enum logic [1:0] {
        SB = 2'd0,
        SH = 2'd1,
        SW = 2'd2
    } store_op_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } store_entry_type;

endpackage
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// ============================================================================
// Module      : store_fifo
// Description : Two-entry in-order FIFO of prepared store entries.
// Revision    : 1.0 - initial release
// ============================================================================
module store_fifo
    import store_buffer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  store_entry_type i_push_entry,
    input  logic            i_pop,
    output store_entry_type o_head,
    output logic            o_valid,
    output logic [1:0]      o_count
);

    store_entry_type r_entries [STORE_DEPTH];
    logic            r_wptr;
    logic            r_rptr;
    logic [1:0]      r_count;
    logic            r_valid;

    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_count_next;

    assign w_push = i_push & (r_count != 2'(STORE_DEPTH));
    assign w_pop  = i_pop & r_valid;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Valid is kept as its own flop so the memory side sees a clean registered signal.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STORE_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_entries[r_wptr] <= i_push_entry;
                r_wptr            <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != 2'd0);
        end
    end

    assign o_head  = r_entries[r_rptr];
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Aligns store requests, builds strobes/lane data, queues them.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_op,
    output logic        st_fault,
    output logic [31:0] st_fault_addr,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    output logic        empty
);

    store_entry_type w_entry;
    store_entry_type w_head;
    logic            w_legal;
    logic            w_accept;
    logic            w_valid;
    logic [1:0]      w_count;
    logic [1:0]      w_lane;

    logic            r_fault;
    logic [31:0]     r_fault_addr;

    assign w_lane = st_addr[1:0];

    // Lane placement mirrors the load extractor's byte-enable convention.
    always_comb begin
        w_entry.addr  = {st_addr[31:2], 2'b00};
        w_entry.wdata = st_data;
        w_entry.strb  = 4'hF;
        w_legal       = 1'b0;
        case (st_op)
            SB: begin
                w_entry.strb  = 4'b0001 << w_lane;
                w_entry.wdata = {4{st_data[7:0]}};
                w_legal       = 1'b1;
            end
            SH: begin
                w_entry.strb  = 4'b0011 << w_lane;
                w_entry.wdata = {2{st_data[15:0]}};
                w_legal       = ~w_lane[0];
            end
            SW: begin
                w_entry.strb  = 4'hF;
                w_entry.wdata = st_data;
                w_legal       = (w_lane == 2'd0);
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // No bypass: a full buffer refuses even when it drains in the same cycle.
    assign st_ready = ~reset & (w_count < 2'(STORE_DEPTH));
    assign w_accept = st_valid & st_ready;

    store_fifo u_fifo (
        .clk          (clock),
        .rst          (reset),
        .i_push       (w_accept & w_legal),
        .i_push_entry (w_entry),
        .i_pop        (mem_ready),
        .o_head       (w_head),
        .o_valid      (w_valid),
        .o_count      (w_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fault      <= 1'b0;
            r_fault_addr <= 32'd0;
        end else begin
            r_fault <= w_accept & ~w_legal;
            if (w_accept & ~w_legal) begin
                r_fault_addr <= st_addr;
            end
        end
    end

    assign st_fault      = r_fault;
    assign st_fault_addr = r_fault_addr;
    assign mem_valid     = w_valid;
    assign mem_addr      = w_head.addr;
    assign mem_wdata     = w_head.wdata;
    assign mem_strb      = w_head.strb;
    assign empty         = (w_count == 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_op;
    logic        st_fault;
    logic [31:0] st_fault_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        empty;

    store_buffer dut (
        .clock         (clock),
        .reset         (reset),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_op         (st_op),
        .st_fault      (st_fault),
        .st_fault_addr (st_fault_addr),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_strb      (mem_strb),
        .empty         (empty)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    store_entry_type model_q[$];
    logic            exp_fault      = 1'b0;
    logic [31:0]     exp_fault_addr = 32'd0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: access size is 1<<op bytes, legal when the lane is a multiple of it.
    function automatic store_entry_type ref_entry(input logic [1:0] op, input logic [31:0] addr,
                                                  input logic [31:0] data, output logic legal);
        store_entry_type e;
        int lane;
        int size;
        lane   = int'(addr[1:0]);
        size   = 1 << int'(op);
        legal  = (op != 2'd3) && ((lane % size) == 0);
        e.addr = addr & ~32'h3;
        case (op)
            2'd0: begin e.wdata = {24'd0, data[7:0]} * 32'h0101_0101;  e.strb = 4'(1 << lane); end
            2'd1: begin e.wdata = {16'd0, data[15:0]} * 32'h0001_0001; e.strb = 4'(3 << lane); end
            default: begin e.wdata = data; e.strb = 4'hF; end
        endcase
        return e;
    endfunction

    task automatic step();
        logic            accept;
        logic            pop;
        logic            legal;
        store_entry_type e;
        pop    = (model_q.size() != 0) && mem_ready;
        accept = st_valid && !reset && (model_q.size() < 2);
        e      = ref_entry(st_op, st_addr, st_data, legal);
        @(posedge clock);
        #1;
        if (reset) begin
            model_q.delete();
            exp_fault      = 1'b0;
            exp_fault_addr = 32'd0;
        end else begin
            if (pop) void'(model_q.pop_front());
            exp_fault = accept && !legal;
            if (exp_fault) exp_fault_addr = st_addr;
            if (accept && legal) model_q.push_back(e);
        end
        check("mem_valid", 32'(mem_valid), 32'(model_q.size() != 0));
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("st_ready", 32'(st_ready), 32'(!reset && model_q.size() < 2));
        check("st_fault", 32'(st_fault), 32'(exp_fault));
        check("st_fault_addr", st_fault_addr, exp_fault_addr);
        if (model_q.size() != 0) begin
            check("mem_addr", mem_addr, model_q[0].addr);
            check("mem_wdata", mem_wdata, model_q[0].wdata);
            check("mem_strb", 32'(mem_strb), 32'(model_q[0].strb));
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data);
        st_valid = v;
        st_op    = op;
        st_addr  = addr;
        st_data  = data;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        step();
        step();
        check("rst_st_ready", 32'(st_ready), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_strb", 32'(mem_strb), 32'd0);
        check("rst_fault_addr", st_fault_addr, 32'd0);
        reset = 1'b0;
        step();

        // Single-request table, each from an empty buffer with memory ready.
        vecs.push_back('{2'd0, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 4'b1000, 32'hDDDD_DDDD});
        vecs.push_back('{2'd1, 32'h0000_2002, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234});
        vecs.push_back('{2'd1, 32'h0000_2001, 32'h0000_1234, 1'b1, 4'b0000, 32'h0});
        vecs.push_back('{2'd0, 32'h0000_0000, 32'h0000_0055, 1'b0, 4'b0001, 32'h5555_5555});
        vecs.push_back('{2'd0, 32'h0000_0002, 32'hFFFF_FF12, 1'b0, 4'b0100, 32'h1212_1212});
        vecs.push_back('{2'd1, 32'h0000_0000, 32'h0000_BEEF, 1'b0, 4'b0011, 32'hBEEF_BEEF});
        vecs.push_back('{2'd1, 32'h0000_0003, 32'h0000_BEEF, 1'b1, 4'b0000, 32'h0});
        vecs.push_back('{2'd2, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'hCAFE_F00D});
        vecs.push_back('{2'd2, 32'h0000_0006, 32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0});
        vecs.push_back('{2'd2, 32'h0000_0003, 32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0});
        vecs.push_back('{2'd3, 32'h0000_0000, 32'h1111_2222, 1'b1, 4'b0000, 32'h0});
        mem_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].addr, vecs[i].data);
            step();
            check("vec_fault", 32'(st_fault), 32'(vecs[i].fault));
            check("vec_valid", 32'(mem_valid), 32'(!vecs[i].fault));
            if (vecs[i].fault) begin
                check("vec_fault_addr", st_fault_addr, vecs[i].addr);
            end else begin
                check("vec_addr", mem_addr, vecs[i].addr & ~32'h3);
                check("vec_strb", 32'(mem_strb), 32'(vecs[i].strb));
                check("vec_wdata", mem_wdata, vecs[i].wdata);
            end
            drive(1'b0, 2'd0, 32'd0, 32'd0);
            step();
            check("vec_fault_pulse", 32'(st_fault), 32'd0);
            check("vec_drained", 32'(mem_valid), 32'd0);
        end

        // Backpressure: two SW fill the buffer, third waits, head holds.
        mem_ready = 1'b0;
        drive(1'b1, 2'd2, 32'h0000_0100, 32'h1111_1111);
        step();
        drive(1'b1, 2'd2, 32'h0000_0104, 32'h2222_2222);
        step();
        check("bp_full_ready", 32'(st_ready), 32'd0);
        drive(1'b1, 2'd2, 32'h0000_0108, 32'h3333_3333);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_addr", mem_addr, 32'h0000_0100);
            check("bp_hold_data", mem_wdata, 32'h1111_1111);
        end
        mem_ready = 1'b1;
        step();
        check("bp_pop_only_addr", mem_addr, 32'h0000_0104);
        check("bp_pop_only_ready", 32'(st_ready), 32'd1);
        step();
        check("bp_third_addr", mem_addr, 32'h0000_0108);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        step();
        check("bp_empty", 32'(empty), 32'd1);

        // Reset with two queued entries discards them.
        mem_ready = 1'b0;
        drive(1'b1, 2'd2, 32'h0000_0200, 32'hAAAA_0000);
        step();
        drive(1'b1, 2'd2, 32'h0000_0204, 32'hBBBB_0000);
        step();
        check("mr_valid_before", 32'(mem_valid), 32'd1);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        reset = 1'b1;
        step();
        check("mr_valid", 32'(mem_valid), 32'd0);
        check("mr_empty", 32'(empty), 32'd1);
        check("mr_fault", 32'(st_fault), 32'd0);
        reset     = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("mr_no_drain", 32'(mem_valid), 32'd0);
        end

        // Reserved op faults, the following SW enqueues normally.
        drive(1'b1, 2'd3, 32'h0000_0000, 32'h5A5A_5A5A);
        step();
        check("op3_fault", 32'(st_fault), 32'd1);
        check("op3_no_enq", 32'(mem_valid), 32'd0);
        drive(1'b1, 2'd2, 32'h0000_0040, 32'h0BAD_CAFE);
        step();
        check("op3_after_fault", 32'(st_fault), 32'd0);
        check("op3_after_addr", mem_addr, 32'h0000_0040);
        check("op3_after_fault_addr", st_fault_addr, 32'h0000_0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 4) != 0, 2'($urandom % 4),
                  {20'd0, 12'($urandom)}, $urandom);
            mem_ready = ($urandom % 3) != 0;
            reset     = ($urandom % 250) == 0;
            step();
        end
        reset = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        mem_ready = 1'b1;
        step();
        step();
        check("final_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
